// File: rtl/beat_sequencer.sv
// Beat sequencer: turns the asynchronous tempo clock into one-cycle beat ticks
// and steps the song ROM address, with play/pause, restart and loop-or-stop.
//
// state | meaning
// IDLE  | parked at beat 0, waiting for play
// PLAY  | advancing ibeat on every tempo tick
// PAUSE | ibeat frozen, tempo ticks ignored
// DONE  | end of song reached with looping off; waits for restart
module beat_sequencer #(
    parameter int ADDR_W    = 9,
    parameter int LAST_BEAT = 511
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_clk,
    input  logic              play,
    input  logic              restart,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] ibeat,
    output logic              beat_tick,
    output logic              playing,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_BEAT);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ibeat_nxt;
    logic              beat_tick_nxt;
    logic              s0;
    logic              s1;
    logic              s2;
    logic              tick;

    // s0/s1 resolve metastability; s2 is only the edge-detect history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s0 <= play_clk;
            s1 <= s0;
            s2 <= s1;
        end
    end

    assign tick = s1 & ~s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ibeat     <= '0;
            beat_tick <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ibeat     <= ibeat_nxt;
            beat_tick <= beat_tick_nxt;
            playing   <= (state_nxt == PLAY);
            done      <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt     = state;
        ibeat_nxt     = ibeat;
        beat_tick_nxt = 1'b0;
        if (restart) begin
            state_nxt = IDLE;
            ibeat_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ibeat_nxt = '0;
                    if (play) state_nxt = PLAY;
                end
                // A pause request beats a tick arriving in the same cycle.
                PLAY: begin
                    if (!play) begin
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        if (ibeat != LAST) begin
                            ibeat_nxt     = ibeat + ADDR_W'(1);
                            beat_tick_nxt = 1'b1;
                        end else if (loop_en) begin
                            ibeat_nxt     = '0;
                            beat_tick_nxt = 1'b1;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (play) state_nxt = PLAY;
                end
                DONE: begin
                    ibeat_nxt = LAST;
                end
                default: begin
                    state_nxt = IDLE;
                    ibeat_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Consumer end of the tempo clock produced by the speed controller.
- Turns the free-running `play_clk` into one-cycle beat ticks in the `clk` domain.
- Advances the beat address `ibeat` that indexes the music/note ROM.
- Handles play/pause, restart and loop-or-stop at end of song, and flags song completion to the top level.

Parameters:
- ADDR_W, 9, width of `ibeat`.
- LAST_BEAT, 511, index of the final beat of the song; must be < 2**ADDR_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- play_clk  input  1  tempo clock from the speed controller; treated as asynchronous to `clk`.
- play  input  1  level: 1 = play requested, 0 = pause requested.
- restart  input  1  single-cycle pulse, already debounced and one-pulsed; returns to beat 0.
- loop_en  input  1  1 = wrap to beat 0 after LAST_BEAT; 0 = stop at end.
- ibeat  output  ADDR_W  current beat address.
- beat_tick  output  1  registered; high for exactly one cycle when `ibeat` changes due to a tick.
- playing  output  1  registered; high while in PLAY.
- done  output  1  registered; high while in DONE.

Behaviour:

Reset (`rst` low, asynchronous):
- state = IDLE, ibeat = 0, beat_tick = 0, playing = 0, done = 0.
- Synchronizer flops are cleared to 0.
- Reset mid-operation aborts everything immediately; no partial beat is retained.

Tick generation:
- Three-flop chain: s0 <= play_clk, s1 <= s0, s2 <= s1.
- tick = s1 & ~s2 (rising edge of `play_clk`).
- Latency: a `play_clk` rise first sampled at clk edge N gives tick high during cycle N+1. Any `ibeat` update and `beat_tick` appear after clk edge N+2.
- High or low phases of `play_clk` shorter than one `clk` period may be missed; this is acceptable.
- A period change of `play_clk` (speed change) needs no special handling; the block follows edges only.

State machine (IDLE, PLAY, PAUSE, DONE):
- IDLE: ibeat = 0.
  - play = 1 → PLAY. Ticks in IDLE are ignored.
- PLAY: on tick:
  - If ibeat != LAST_BEAT: ibeat + 1, beat_tick = 1.
  - If ibeat == LAST_BEAT and loop_en = 1: ibeat = 0, beat_tick = 1, stay in PLAY.
  - If ibeat == LAST_BEAT and loop_en = 0: → DONE, ibeat holds LAST_BEAT, beat_tick = 0.
  - play = 0 → PAUSE. Pause wins over a same-cycle tick: no advance, no beat_tick.
- PAUSE: ibeat held; ticks ignored.
  - play = 1 → PLAY; the next tick advances normally.
- DONE: ibeat held at LAST_BEAT; ticks and `play` ignored.
  - Leaves only via restart or reset.

Restart and priority:
- restart in any state, next cycle: state = IDLE, ibeat = 0, done = 0, beat_tick = 0.
- restart has priority over tick, play and end-of-song handling in the same cycle.
- If play = 1 while in IDLE after restart, PLAY is entered on the following cycle.

Sampling and arithmetic:
- loop_en is sampled only on the tick evaluated at ibeat == LAST_BEAT; changes at other times have no effect.
- The increment is ADDR_W wide and never wraps via overflow; the wrap is explicit at LAST_BEAT.

Output timing:
- playing = (state == PLAY) and done = (state == DONE), both registered.
- Both change in the same cycle the state register changes.
- beat_tick is never high in IDLE, PAUSE or DONE.

Test Plan:
1. Reset: hold rst = 0 with play = 1 and `play_clk` toggling → ibeat = 0, beat_tick = 0, playing = 0, done = 0 throughout. Release → playing = 1 one cycle later.
2. Play with ADDR_W = 3, LAST_BEAT = 7, play_clk period 20 clk → ibeat steps 0→1→2→… once per `play_clk` rise, each change exactly 3 clk edges after the sampled rise, one beat_tick per step.
3. Pause: play = 0 at ibeat = 3 for 3 `play_clk` periods → ibeat stays 3, no beat_tick. play = 1 → next rise gives ibeat = 4.
4. End of song:
   - loop_en = 1 → 7→0 with beat_tick, playing stays 1.
   - loop_en = 0 → ibeat stays 7, done = 1, playing = 0; further rises and play toggles change nothing.
5. Restart collisions:
   - restart in the same cycle as a tick at ibeat = 5 → ibeat = 0, beat_tick = 0, state IDLE, then PLAY.
   - restart in DONE → done clears next cycle.
6. Reset mid-play at ibeat = 6 → outputs return to reset values immediately (asynchronously). After release with play = 1, the sequence restarts from 0.
